// File: rtl/cu_decode_stage.sv
// Registered decode stage: turns IR into the execute control bundle held in ID/EX,
// with load-use stall detection, stall/flush handling, illegal flagging and interrupt draining.
module cu_decode_stage #(
  parameter int REG_AW           = 5,
  parameter int HAZARD_EN        = 1,
  parameter int INT_FLUSH_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid_i,
  input  logic [31:0]       ir,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              int_taken,
  output logic              id_stall_o,
  output logic              int_ack,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_fun,
  output logic [1:0]        ex_srcA_sel,
  output logic [2:0]        ex_srcB_sel,
  output logic [1:0]        ex_rf_sel,
  output logic              ex_rf_we,
  output logic              ex_mem_we2,
  output logic              ex_mem_rden2,
  output logic              ex_csr_we,
  output logic              ex_mret,
  output logic              ex_is_branch,
  output logic              ex_jal,
  output logic              ex_jalr,
  output logic              ex_illegal,
  output logic [2:0]        ex_funct3,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [3:0] CNT_INIT = 4'(INT_FLUSH_CYCLES - 1);

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_fun;
    logic [1:0]        srcA_sel;
    logic [2:0]        srcB_sel;
    logic [1:0]        rf_sel;
    logic              rf_we;
    logic              mem_we2;
    logic              mem_rden2;
    logic              csr_we;
    logic              mret;
    logic              is_branch;
    logic              jal;
    logic              jalr;
    logic              illegal;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ctrl_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ACK} state_t;

  ctrl_t      dec, ex_d, ex_q;
  state_t     state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       legal, reads_rs1, reads_rs2, uses_rd;
  logic       hazard, int_bubble, drain_stall;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];

  always_comb begin
    dec           = '0;
    legal         = 1'b1;
    reads_rs1     = 1'b0;
    reads_rs2     = 1'b0;
    uses_rd       = 1'b0;
    dec.funct3    = funct3;
    dec.rd        = ir[7 +: REG_AW];
    dec.rs1       = ir[15 +: REG_AW];
    dec.rs2       = ir[20 +: REG_AW];
    case (opcode)
      OP_R: begin
        reads_rs1   = 1'b1;
        reads_rs2   = 1'b1;
        uses_rd     = 1'b1;
        dec.rf_sel  = 2'd3;
        dec.rf_we   = 1'b1;
        dec.alu_fun = {ir[30], funct3};
        if (ir[31] || (ir[29:25] != 5'd0) ||
            (ir[30] && (funct3 != 3'b000) && (funct3 != 3'b101)))
          legal = 1'b0;
      end
      OP_IMM: begin
        reads_rs1    = 1'b1;
        uses_rd      = 1'b1;
        dec.srcB_sel = 3'd1;
        dec.rf_sel   = 2'd3;
        dec.rf_we    = 1'b1;
        // Only shifts use funct7; other immediates keep ir[30] as an immediate bit.
        if (funct3 == 3'b101) begin
          dec.alu_fun = {ir[30], funct3};
          if (ir[31] || (ir[29:25] != 5'd0)) legal = 1'b0;
        end else if (funct3 == 3'b001) begin
          dec.alu_fun = 4'b0001;
          if (ir[31:25] != 7'd0) legal = 1'b0;
        end else begin
          dec.alu_fun = {1'b0, funct3};
        end
      end
      OP_LOAD: begin
        reads_rs1     = 1'b1;
        uses_rd       = 1'b1;
        dec.srcB_sel  = 3'd1;
        dec.rf_sel    = 2'd2;
        dec.rf_we     = 1'b1;
        dec.mem_rden2 = 1'b1;
        if ((funct3 == 3'b011) || (funct3[2:1] == 2'b11)) legal = 1'b0;
      end
      OP_STORE: begin
        reads_rs1    = 1'b1;
        reads_rs2    = 1'b1;
        dec.srcB_sel = 3'd2;
        dec.mem_we2  = 1'b1;
        if ((funct3 == 3'b011) || funct3[2]) legal = 1'b0;
      end
      OP_LUI: begin
        uses_rd      = 1'b1;
        dec.srcA_sel = 2'd1;
        dec.alu_fun  = 4'b1001;
        dec.rf_sel   = 2'd3;
        dec.rf_we    = 1'b1;
      end
      OP_AUIPC: begin
        uses_rd      = 1'b1;
        dec.srcA_sel = 2'd1;
        dec.srcB_sel = 3'd3;
        dec.rf_sel   = 2'd3;
        dec.rf_we    = 1'b1;
      end
      OP_JAL: begin
        uses_rd   = 1'b1;
        dec.jal   = 1'b1;
        dec.rf_we = 1'b1;
      end
      OP_JALR: begin
        reads_rs1    = 1'b1;
        uses_rd      = 1'b1;
        dec.jalr     = 1'b1;
        dec.srcB_sel = 3'd1;
        dec.rf_we    = 1'b1;
        if (funct3 != 3'b000) legal = 1'b0;
      end
      OP_BRANCH: begin
        reads_rs1     = 1'b1;
        reads_rs2     = 1'b1;
        dec.is_branch = 1'b1;
        if (funct3[2:1] == 2'b01) legal = 1'b0;
      end
      OP_SYS: begin
        reads_rs1 = 1'b1;
        case (funct3)
          3'b001: begin
            uses_rd     = 1'b1;
            dec.alu_fun = 4'b1001;
            dec.rf_sel  = 2'd1;
            dec.rf_we   = 1'b1;
            dec.csr_we  = 1'b1;
          end
          3'b010: begin
            uses_rd      = 1'b1;
            dec.alu_fun  = 4'b0110;
            dec.srcB_sel = 3'd4;
            dec.rf_sel   = 2'd1;
            dec.rf_we    = 1'b1;
            dec.csr_we   = 1'b1;
          end
          3'b011: begin
            uses_rd      = 1'b1;
            dec.alu_fun  = 4'b0111;
            dec.srcA_sel = 2'd2;
            dec.srcB_sel = 3'd4;
            dec.rf_sel   = 2'd1;
            dec.rf_we    = 1'b1;
            dec.csr_we   = 1'b1;
          end
          3'b000: begin
            if (ir[31:20] == 12'h302) dec.mret = 1'b1;
            else legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Narrow register files reject any register field that needs the dropped MSB.
    if ((REG_AW < 5) && ((uses_rd && ir[11]) || (reads_rs1 && ir[19]) || (reads_rs2 && ir[24])))
      legal = 1'b0;
    if (dec.rd == '0) dec.rf_we = 1'b0;
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign hazard = (HAZARD_EN != 0) && id_valid_i && legal && ex_q.valid && ex_q.mem_rden2 &&
                  (ex_q.rd != '0) &&
                  ((reads_rs1 && (ir[15 +: REG_AW] == ex_q.rd)) ||
                   (reads_rs2 && (ir[20 +: REG_AW] == ex_q.rd)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (int_taken) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_INIT;
        end
      end
      ST_DRAIN: begin
        if (!stall_i) begin
          if (cnt_q == 4'd0) state_d = ST_ACK;
          else cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    int_ack     = (state_q == ST_ACK);
    drain_stall = (state_q == ST_DRAIN);
    int_bubble  = (state_q != ST_RUN) || int_taken;
  end

  assign id_stall_o = stall_i || drain_stall || hazard;

  // Flush beats stall; every other bubble source waits behind a downstream stall.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall_i) begin
      ex_d = ex_q;
    end else if (int_bubble || hazard || !id_valid_i) begin
      ex_d = '0;
    end else begin
      ex_d       = dec;
      ex_d.valid = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_alu_fun   = ex_q.alu_fun;
  assign ex_srcA_sel  = ex_q.srcA_sel;
  assign ex_srcB_sel  = ex_q.srcB_sel;
  assign ex_rf_sel    = ex_q.rf_sel;
  assign ex_rf_we     = ex_q.rf_we;
  assign ex_mem_we2   = ex_q.mem_we2;
  assign ex_mem_rden2 = ex_q.mem_rden2;
  assign ex_csr_we    = ex_q.csr_we;
  assign ex_mret      = ex_q.mret;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_jal       = ex_q.jal;
  assign ex_jalr      = ex_q.jalr;
  assign ex_illegal   = ex_q.illegal;
  assign ex_funct3    = ex_q.funct3;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;

endmodule

// File: tb/tb_cu_decode_stage.sv
// Directed bench for cu_decode_stage: default build, a hazard-disabled build and an RV32E build
// all see the same stimulus; expected values are hand-computed per vector.
module tb_cu_decode_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        idValid, stallIn, flushIn, intTaken;
  logic [31:0] irIn;

  int checks = 0;
  int errors = 0;

  // Default instance outputs
  logic aStall, aAck, aValid, aRfWe, aMemWe, aMemRd, aCsrWe, aMret, aBr, aJal, aJalr, aIll;
  logic [3:0] aAlu;
  logic [1:0] aSrcA, aRfSel;
  logic [2:0] aSrcB, aF3;
  logic [4:0] aRd, aRs1, aRs2;

  // HAZARD_EN=0 instance outputs
  logic nStall, nAck, nValid, nRfWe, nMemWe, nMemRd, nCsrWe, nMret, nBr, nJal, nJalr, nIll;
  logic [3:0] nAlu;
  logic [1:0] nSrcA, nRfSel;
  logic [2:0] nSrcB, nF3;
  logic [4:0] nRd, nRs1, nRs2;

  // REG_AW=4 instance outputs
  logic eStall, eAck, eValid, eRfWe, eMemWe, eMemRd, eCsrWe, eMret, eBr, eJal, eJalr, eIll;
  logic [3:0] eAlu;
  logic [1:0] eSrcA, eRfSel;
  logic [2:0] eSrcB, eF3;
  logic [3:0] eRd, eRs1, eRs2;

  always #5 CLK = ~CLK;

  cu_decode_stage dut (
    .CLK(CLK), .RST(RST), .id_valid_i(idValid), .ir(irIn), .stall_i(stallIn), .flush_i(flushIn),
    .int_taken(intTaken), .id_stall_o(aStall), .int_ack(aAck), .ex_valid(aValid),
    .ex_alu_fun(aAlu), .ex_srcA_sel(aSrcA), .ex_srcB_sel(aSrcB), .ex_rf_sel(aRfSel),
    .ex_rf_we(aRfWe), .ex_mem_we2(aMemWe), .ex_mem_rden2(aMemRd), .ex_csr_we(aCsrWe),
    .ex_mret(aMret), .ex_is_branch(aBr), .ex_jal(aJal), .ex_jalr(aJalr), .ex_illegal(aIll),
    .ex_funct3(aF3), .ex_rd(aRd), .ex_rs1(aRs1), .ex_rs2(aRs2)
  );

  cu_decode_stage #(.HAZARD_EN(0)) dutNoHaz (
    .CLK(CLK), .RST(RST), .id_valid_i(idValid), .ir(irIn), .stall_i(stallIn), .flush_i(flushIn),
    .int_taken(intTaken), .id_stall_o(nStall), .int_ack(nAck), .ex_valid(nValid),
    .ex_alu_fun(nAlu), .ex_srcA_sel(nSrcA), .ex_srcB_sel(nSrcB), .ex_rf_sel(nRfSel),
    .ex_rf_we(nRfWe), .ex_mem_we2(nMemWe), .ex_mem_rden2(nMemRd), .ex_csr_we(nCsrWe),
    .ex_mret(nMret), .ex_is_branch(nBr), .ex_jal(nJal), .ex_jalr(nJalr), .ex_illegal(nIll),
    .ex_funct3(nF3), .ex_rd(nRd), .ex_rs1(nRs1), .ex_rs2(nRs2)
  );

  cu_decode_stage #(.REG_AW(4)) dutRv32e (
    .CLK(CLK), .RST(RST), .id_valid_i(idValid), .ir(irIn), .stall_i(stallIn), .flush_i(flushIn),
    .int_taken(intTaken), .id_stall_o(eStall), .int_ack(eAck), .ex_valid(eValid),
    .ex_alu_fun(eAlu), .ex_srcA_sel(eSrcA), .ex_srcB_sel(eSrcB), .ex_rf_sel(eRfSel),
    .ex_rf_we(eRfWe), .ex_mem_we2(eMemWe), .ex_mem_rden2(eMemRd), .ex_csr_we(eCsrWe),
    .ex_mret(eMret), .ex_is_branch(eBr), .ex_jal(eJal), .ex_jalr(eJalr), .ex_illegal(eIll),
    .ex_funct3(eF3), .ex_rd(eRd), .ex_rs1(eRs1), .ex_rs2(eRs2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 ns after a rising edge and settle 1 ns before combinational checks.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic st,
                               input logic fl, input logic it);
    idValid  = v;
    irIn     = instr;
    stallIn  = st;
    flushIn  = fl;
    intTaken = it;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [31:0] ADD_X3  = 32'h002081B3;
  localparam logic [31:0] ADDI_X0 = 32'h00000013;
  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_X6  = 32'h00228333;
  localparam logic [31:0] SUB_X7  = 32'h402083B3;
  localparam logic [31:0] ADD_X16 = 32'h00208833;
  localparam logic [31:0] BEQ     = 32'h00208063;
  localparam logic [31:0] CSRRW   = 32'h300110F3;
  localparam logic [31:0] MRET    = 32'h30200073;
  localparam logic [31:0] LUI_X4  = 32'h12345237;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst ex_valid", aValid, 0);
    checkOutput("rst int_ack", aAck, 0);
    checkOutput("rst id_stall", aStall, 0);
    checkOutput("rst ex_rd", aRd, 0);
    RST = 1'b0;

    applyStimulus(1'b1, ADD_X3, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("add valid", aValid, 1);
    checkOutput("add alu", aAlu, 4'b0000);
    checkOutput("add srcB", aSrcB, 0);
    checkOutput("add rf_sel", aRfSel, 3);
    checkOutput("add rf_we", aRfWe, 1);
    checkOutput("add rd", aRd, 3);
    checkOutput("add rs1", aRs1, 1);
    checkOutput("add rs2", aRs2, 2);
    checkOutput("add rv32e legal", eIll, 0);

    applyStimulus(1'b1, ADDI_X0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("nop valid", aValid, 1);
    checkOutput("nop rf_we x0", aRfWe, 0);
    checkOutput("nop srcB", aSrcB, 1);

    // Load followed by a dependent add
    applyStimulus(1'b1, LW_X5, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("lw rden", aMemRd, 1);
    checkOutput("lw rf_sel", aRfSel, 2);
    checkOutput("lw funct3", aF3, 3'b010);
    checkOutput("lw rd", aRd, 5);
    applyStimulus(1'b1, ADD_X6, 1'b0, 1'b0, 1'b0);
    checkOutput("hazard stall", aStall, 1);
    checkOutput("nohaz stall", nStall, 0);
    tick();
    checkOutput("hazard bubble", aValid, 0);
    checkOutput("nohaz issue valid", nValid, 1);
    checkOutput("nohaz issue rd", nRd, 6);
    checkOutput("hazard released", aStall, 0);
    tick();
    checkOutput("dep add valid", aValid, 1);
    checkOutput("dep add rd", aRd, 6);

    // Downstream stall holds ID/EX, flush overrides stall
    applyStimulus(1'b1, SUB_X7, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("sub alu", aAlu, 4'b1000);
    applyStimulus(1'b1, ADD_X3, 1'b1, 1'b0, 1'b0);
    checkOutput("stall id_stall", aStall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall hold alu", aAlu, 4'b1000);
      checkOutput("stall hold rd", aRd, 7);
      checkOutput("stall hold valid", aValid, 1);
    end
    applyStimulus(1'b1, ADD_X3, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("flush valid", aValid, 0);
    checkOutput("flush alu", aAlu, 0);
    checkOutput("flush rd", aRd, 0);

    // Illegal encodings and idle slots
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ill valid", aValid, 1);
    checkOutput("ill flag", aIll, 1);
    checkOutput("ill rf_we", aRfWe, 0);
    checkOutput("ill mem_we2", aMemWe, 0);
    checkOutput("ill rd", aRd, 0);
    applyStimulus(1'b0, ADD_X3, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("idle bubble", aValid, 0);
    applyStimulus(1'b1, ADD_X16, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rv32e x16 illegal", eIll, 1);
    checkOutput("rv32e x16 valid", eValid, 1);
    checkOutput("rv32e x16 rf_we", eRfWe, 0);
    checkOutput("rv32i x16 legal", aIll, 0);
    checkOutput("rv32i x16 rd", aRd, 16);

    // Other classes
    applyStimulus(1'b1, BEQ, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("beq branch", aBr, 1);
    checkOutput("beq alu", aAlu, 0);
    checkOutput("beq rf_we", aRfWe, 0);
    applyStimulus(1'b1, CSRRW, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("csrrw csr_we", aCsrWe, 1);
    checkOutput("csrrw rf_we", aRfWe, 1);
    checkOutput("csrrw rf_sel", aRfSel, 1);
    applyStimulus(1'b1, MRET, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("mret flag", aMret, 1);
    checkOutput("mret csr_we", aCsrWe, 0);
    checkOutput("mret rf_we", aRfWe, 0);
    applyStimulus(1'b1, LUI_X4, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("lui alu", aAlu, 4'b1001);
    checkOutput("lui srcA", aSrcA, 1);
    checkOutput("lui rd", aRd, 4);

    // Interrupt drain: two bubbles, ack on the third cycle, second request ignored
    applyStimulus(1'b1, ADD_X3, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, ADD_X3, 1'b0, 1'b0, 1'b0);
    checkOutput("drain1 valid", aValid, 0);
    checkOutput("drain1 ack", aAck, 0);
    checkOutput("drain1 stall", aStall, 1);
    applyStimulus(1'b1, ADD_X3, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, ADD_X3, 1'b0, 1'b0, 1'b0);
    checkOutput("drain2 valid", aValid, 0);
    checkOutput("drain2 ack", aAck, 0);
    tick();
    checkOutput("ack pulse", aAck, 1);
    checkOutput("ack valid", aValid, 0);
    checkOutput("ack stall", aStall, 0);
    tick();
    checkOutput("post ack", aAck, 0);
    checkOutput("post ack bubble", aValid, 0);
    tick();
    checkOutput("resume valid", aValid, 1);
    checkOutput("resume ack", aAck, 0);

    // Reset in the middle of a drain
    applyStimulus(1'b1, ADD_X3, 1'b0, 1'b0, 1'b1);
    tick();
    RST = 1'b1;
    applyStimulus(1'b1, ADD_X3, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
    #1;
    checkOutput("mid rst valid", aValid, 0);
    checkOutput("mid rst ack", aAck, 0);
    checkOutput("mid rst run", aStall, 0);
    tick();
    checkOutput("post rst valid", aValid, 1);
    checkOutput("post rst ack", aAck, 0);
    tick();
    checkOutput("post rst ack2", aAck, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_decode_stage.md
Name: cu_decode_stage

Overview:
Registered decode stage of the pipelined core. It decodes IR into the control bundle and holds it in the ID/EX pipeline register with a valid bit. It adds load-use hazard detection, stall/flush handling, illegal-instruction flagging and an interrupt bubble-injection FSM, none of which the combinational decoder has. It sits between the IF/ID register and the execute stage, and drives the IF stall.

Parameters:
REG_AW, 5, register-address width; 4 selects RV32E (rd/rs1/rs2 MSB set -> illegal)
HAZARD_EN, 1, 1 enables load-use stall detection; 0 disables it (id_stall_o follows stall_i only)
INT_FLUSH_CYCLES, 2, bubbles injected after int_taken before int_ack (1..15)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
id_valid_i  in  1  IR holds a valid instruction
ir  in  32  instruction word
stall_i  in  1  downstream stall; hold ID/EX register
flush_i  in  1  taken branch/jump from EX; squash ID/EX
int_taken  in  1  interrupt accepted; start bubble sequence
id_stall_o  out  1  hold PC and IF/ID register
int_ack  out  1  one-cycle pulse; pipeline drained, redirect to mtvec
ex_valid  out  1  ID/EX entry valid
ex_alu_fun  out  4  add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, copy 1001, sra 1101
ex_srcA_sel  out  2  0 rs1, 1 U-imm, 2 ~rs1
ex_srcB_sel  out  3  0 rs2, 1 I-imm, 2 S-imm, 3 PC, 4 CSR
ex_rf_sel  out  2  0 PC+4, 1 CSR, 2 mem dout2, 3 ALU
ex_rf_we, ex_mem_we2, ex_mem_rden2  out  1 each  write-enables and read-enable
ex_csr_we, ex_mret, ex_is_branch, ex_jal, ex_jalr, ex_illegal  out  1 each  class flags
ex_funct3  out  3  funct3 (branch type, load/store size)
ex_rd, ex_rs1, ex_rs2  out  REG_AW each  register addresses

Behaviour:
- Latency 1: a decoded instruction appears on ex_* the cycle after it is sampled.
- Bubble: ex_valid=0 and every control/flag/address output 0. On RST: bubble, FSM=RUN, counter 0, int_ack=0.
- Decode: R/I/load/store/lui/auipc/jal/jalr use the encodings above. Branch opcode 1100011 sets ex_is_branch with ALU add.
- CSR (opcode 1110011): csrrw/csrrs/csrrc set RF_WE=1 and csr_we=1. funct3=000 with ir[31:20]=0x302 is mret (ex_mret=1, no writes).
- ex_rf_we forced 0 when rd==0.
- Illegal: unknown opcode, unlisted funct3, or out-of-range register MSB. Result is ex_valid=1, ex_illegal=1, all other controls 0.
- Load-use hazard (HAZARD_EN=1): fires when ex_valid & ex_mem_rden2 & ex_rd!=0 & the ID instruction reads ex_rd.
  - rs1 is read by all classes except lui/auipc/jal.
  - rs2 is read by R/store/branch.
  - On a hazard, id_stall_o=1 combinationally and a bubble is loaded into ID/EX (one cycle).
- stall_i=1: ID/EX holds its value and id_stall_o=1.
- Update priority per cycle: RST > flush_i > stall_i > interrupt FSM bubble > hazard bubble > decode.
  - flush_i loads a bubble even while stall_i=1.
  - flush_i does not reset the interrupt FSM.
- id_valid_i=0 loads a bubble.
- Interrupt FSM states: RUN, DRAIN, ACK.
  - RUN: int_taken=1 -> DRAIN, load cnt=INT_FLUSH_CYCLES-1, and the current ID instruction is discarded (bubble).
  - DRAIN: bubble each cycle, id_stall_o=1. cnt==0 -> ACK, else cnt-1. stall_i freezes the counter.
  - ACK: int_ack=1 for exactly one cycle and a bubble is loaded, then -> RUN.
  - int_taken is ignored outside RUN.
- The decoder takes no state from ir beyond the current cycle.

Test Plan:
- add x3,x1,x2 (0x002081B3) valid -> next cycle ex_valid=1, alu 0000, srcB 0, rf_sel 3, rf_we 1, rd=3. addi x0,x0,0 -> rf_we=0.
- lw x5,0(x1), then add x6,x5,x2 -> id_stall_o=1 for 1 cycle, one bubble, then add issues. With HAZARD_EN=0 -> no stall.
- stall_i=1 for 3 cycles holding sub -> ex_* constant (alu 1000). flush_i and stall_i together -> ex_valid=0 next cycle.
- int_taken pulse with INT_FLUSH_CYCLES=2 -> bubbles for 2 cycles, int_ack high on 3rd cycle only. A second int_taken during DRAIN is ignored.
- ir=0xFFFFFFFF -> ex_illegal=1, ex_valid=1, rf_we=0, mem_we2=0. REG_AW=4 with add x16,... -> illegal.
- RST asserted mid-DRAIN with a valid decode in flight -> next cycle ex_valid=0, int_ack=0, FSM RUN.
